enc_pack_scheduler: RTL and testbench
=====================================

// Module: enc_pack_scheduler
// PURPOSE
//  Sequences the encoder's binder packs (10 binders each) one pack at a time: pulses that pack's start_encoding,
//  waits the binder latency, then strobes the bundler to accumulate that pack's shifted HVs.
//  Sits between the sample loader (upstream valid/ready) and the bundler/accumulator (downstream valid/ready).
//  One encoded sample per pass over all packs.
// PARAMETERS
//  NUM_PACKS     62  number of binder packs, NUM_PACKS >= 1.
//  BIND_LATENCY  1   cycles from start_encoding to stable shifted_hv, 0..15.
//  IDX_W         $clog2(NUM_PACKS) (min 1) width of pack_sel; derived, not overridden.
// PORTS
//  clk             in   1          clock, rising edge
//  nrst            in   1          synchronous reset, active low
//  sample_valid    in   1          upstream has level HVs for a new sample
//  sample_ready    out  1          scheduler idle, can accept a sample
//  start_encoding  out  NUM_PACKS  one-hot per-pack bind start pulse
//  pack_sel        out  IDX_W      pack index driving the bundler input mux
//  accum_clr       out  1          clear bundler accumulator, 1-cycle pulse
//  accum_en        out  1          accumulate the pack_sel pack's outputs, 1-cycle pulse
//  enc_valid       out  1          encoded HV in bundler is complete
//  enc_ready       in   1          downstream consumed encoded HV
//  busy_cycles     out  32         (ENC_SCHED_PERF_EN only) cycles spent outside IDLE
// BEHAVIOUR
//  Reset (nrst=0 at a clk edge): state=IDLE, pack_idx=0, all outputs 0 except sample_ready=1; busy_cycles=0.
//  FSM: IDLE -> BIND -> WAIT -> ACCUM -> (BIND | DONE) -> IDLE.
//  IDLE: sample_ready=1. On sample_valid&&sample_ready: accum_clr=1 that cycle, pack_idx<=0, go BIND.
//  BIND: start_encoding[pack_idx]=1 for exactly one cycle, pack_sel=pack_idx; go WAIT, or ACCUM if BIND_LATENCY=0.
//  WAIT: wait counter counts BIND_LATENCY cycles, then go ACCUM.
//  ACCUM: accum_en=1 one cycle, pack_sel=pack_idx. pack_idx==NUM_PACKS-1 -> DONE; else pack_idx+1 -> BIND.
//  DONE: enc_valid=1, held until enc_ready=1; then IDLE, in the cycle after the handshake.
//  start_encoding is all-zero outside BIND and never has more than one bit set.
//  sample_ready=0 in every state except IDLE. An upstream valid during DONE is held off; it is accepted in IDLE.
//  enc_ready when enc_valid=0 is ignored.
//  Timing: sample accepted at edge 0 -> pack p BIND in cycle 1+p*(2+L), ACCUM in cycle (p+1)*(2+L), L=BIND_LATENCY.
//  enc_valid first high in cycle NUM_PACKS*(2+L)+1. Defaults: BIND cycle 1, ACCUM cycle 3, enc_valid cycle 187.
//  pack_idx wraps only via IDLE reset to 0; no modulo arithmetic.
//  nrst low mid-pass: immediate return to reset state; the partially accumulated sample is discarded.
//  The next accepted sample pulses accum_clr.
// CONFIGURATION
//  ENC_SCHED_PERF_EN defined: busy_cycles increments every cycle state!=IDLE, saturates at 32'hFFFF_FFFF,
//  cleared only by reset.
//  ENC_SCHED_PERF_EN undefined: busy_cycles port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  hdc_pkg (shared) holds HV_DIM, SHIFTS, PACK_SIZE=10, NUM_PACKS, enc_sched_state_t enum
//  (IDLE, BIND, WAIT, ACCUM, DONE).
//  Single module, no sub-modules; the wait counter and pack counter are inline always_ff.
//  The top level wires start_encoding[k] to enc_binder_pack_k.start_encoding.
// TESTING
//  Single sample, defaults, enc_ready=1 -> one start_encoding pulse per pack, in order 0..61;
//  enc_valid in cycle 187; 62 accum_en pulses.
//  Back-to-back: sample_valid held high, enc_ready=1 -> 2nd accepted 1 cycle after DONE handshake;
//  accum_clr once per sample.
//  Backpressure: enc_ready=0 for 20 cycles in DONE -> enc_valid held, sample_ready=0,
//  no start_encoding until release.
//  BIND_LATENCY=0, NUM_PACKS=1 -> BIND cycle 1, ACCUM cycle 2, enc_valid cycle 3.
//  Reset mid-pass: nrst=0 in cycle 50 -> next cycle all outputs at reset values;
//  new sample restarts from pack 0.
//  ENC_SCHED_PERF_EN: one sample at defaults with enc_ready=1 -> busy_cycles=187 back in IDLE.

Source files
------------

// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared HDC encoder constants and pack scheduler state type
package hdc_pkg;

  localparam int HV_DIM    = 10000;
  localparam int PACK_SIZE = 10;
  localparam int NUM_PACKS = 62;
  localparam int SHIFTS    = PACK_SIZE * NUM_PACKS;

  typedef enum logic [2:0] {
    IDLE,
    BIND,
    WAIT,
    ACCUM,
    DONE
  } enc_sched_state_t;

endpackage

// File: rtl/enc_pack_scheduler.sv
// rtl/enc_pack_scheduler.sv - sequences binder packs into the bundler, one sample per pass
// Optional busy-cycle counter when ENC_SCHED_PERF_EN is defined.
module enc_pack_scheduler #(
  parameter int  NUM_PACKS    = hdc_pkg::NUM_PACKS,
  parameter int  BIND_LATENCY = 1,
  localparam int IDX_W        = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [NUM_PACKS-1:0] start_encoding,
  output logic [IDX_W-1:0]     pack_sel,
  output logic                 accum_clr,
  output logic                 accum_en,
  output logic                 enc_valid,
  input  logic                 enc_ready
`ifdef ENC_SCHED_PERF_EN
  ,
  output logic [31:0]          busy_cycles
`endif
);

  import hdc_pkg::*;

  localparam logic [3:0]           WAIT_LAST = 4'((BIND_LATENCY > 0) ? BIND_LATENCY - 1 : 0);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_PACKS - 1);
  localparam logic [NUM_PACKS-1:0] PACK0     = NUM_PACKS'(1);

  enc_sched_state_t state;
  logic [IDX_W-1:0] pack_idx;
  logic [IDX_W-1:0] next_idx;
  logic [3:0]       wait_cnt;

  assign next_idx = pack_idx + 1'b1;
  assign pack_sel = pack_idx;

  // The clear must land in the same cycle as the accepted handshake.
  assign accum_clr = sample_ready && sample_valid;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= IDLE;
      pack_idx       <= '0;
      wait_cnt       <= '0;
      sample_ready   <= 1'b1;
      start_encoding <= '0;
      accum_en       <= 1'b0;
      enc_valid      <= 1'b0;
    end else begin
      start_encoding <= '0;
      accum_en       <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            state          <= BIND;
            pack_idx       <= '0;
            sample_ready   <= 1'b0;
            start_encoding <= PACK0;
          end
        end
        BIND: begin
          if (BIND_LATENCY == 0) begin
            state    <= ACCUM;
            accum_en <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= ACCUM;
            accum_en <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (pack_idx == LAST_IDX) begin
            state     <= DONE;
            enc_valid <= 1'b1;
          end else begin
            state          <= BIND;
            pack_idx       <= next_idx;
            start_encoding <= PACK0 << next_idx;
          end
        end
        DONE: begin
          if (enc_ready) begin
            state        <= IDLE;
            enc_valid    <= 1'b0;
            sample_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          sample_ready <= 1'b1;
          enc_valid    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENC_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_cycles <= '0;
    end else if (state != IDLE && busy_cycles != 32'hFFFF_FFFF) begin
      busy_cycles <= busy_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// tb/tb_enc_pack_scheduler.sv - self-checking bench for enc_pack_scheduler, three parameterisations
module tb_enc_pack_scheduler;

    localparam int ND = 3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int np_of(int id);
        case (id)
            0:       return 62;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int lat_of(int id);
        case (id)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    logic nrst, sample_valid, enc_ready;
    always #5 clk = ~clk;

    logic        sr0, sr1, sr2, clr0, clr1, clr2, en0, en1, en2, ev0, ev1, ev2;
    logic [61:0] se0;
    logic [0:0]  se1;
    logic [3:0]  se2;
    logic [5:0]  ps0;
    logic [0:0]  ps1;
    logic [1:0]  ps2;
`ifdef ENC_SCHED_PERF_EN
    logic [31:0] bc0, bc1, bc2;
    logic [31:0] o_bc [ND];
    assign o_bc[0] = bc0;
    assign o_bc[1] = bc1;
    assign o_bc[2] = bc2;
`endif

    enc_pack_scheduler #(.NUM_PACKS(62), .BIND_LATENCY(1)) dut0 (
        .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sr0),
        .start_encoding(se0), .pack_sel(ps0), .accum_clr(clr0), .accum_en(en0),
        .enc_valid(ev0), .enc_ready(enc_ready)
`ifdef ENC_SCHED_PERF_EN
        , .busy_cycles(bc0)
`endif
    );

    enc_pack_scheduler #(.NUM_PACKS(1), .BIND_LATENCY(0)) dut1 (
        .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sr1),
        .start_encoding(se1), .pack_sel(ps1), .accum_clr(clr1), .accum_en(en1),
        .enc_valid(ev1), .enc_ready(enc_ready)
`ifdef ENC_SCHED_PERF_EN
        , .busy_cycles(bc1)
`endif
    );

    enc_pack_scheduler #(.NUM_PACKS(4), .BIND_LATENCY(3)) dut2 (
        .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sr2),
        .start_encoding(se2), .pack_sel(ps2), .accum_clr(clr2), .accum_en(en2),
        .enc_valid(ev2), .enc_ready(enc_ready)
`ifdef ENC_SCHED_PERF_EN
        , .busy_cycles(bc2)
`endif
    );

    logic [63:0] o_se [ND];
    logic [7:0]  o_ps [ND];
    logic        o_sr [ND], o_clr [ND], o_en [ND], o_ev [ND];
    assign o_se[0] = 64'(se0);
    assign o_se[1] = 64'(se1);
    assign o_se[2] = 64'(se2);
    assign o_ps[0] = 8'(ps0);
    assign o_ps[1] = 8'(ps1);
    assign o_ps[2] = 8'(ps2);
    assign o_sr[0] = sr0;
    assign o_sr[1] = sr1;
    assign o_sr[2] = sr2;
    assign o_clr[0] = clr0;
    assign o_clr[1] = clr1;
    assign o_clr[2] = clr2;
    assign o_en[0] = en0;
    assign o_en[1] = en1;
    assign o_en[2] = en2;
    assign o_ev[0] = ev0;
    assign o_ev[1] = ev1;
    assign o_ev[2] = ev2;

    bit     m_busy [ND];
    int     m_k    [ND];
    longint m_bc   [ND];

    int rel;
    int cnt_se [ND], cnt_en [ND], cnt_clr [ND], cnt_ev [ND], cnt_sr [ND];
    int first_se [ND], first_en [ND], first_ev [ND];

    task automatic clear_stats();
        rel = 0;
        for (int id = 0; id < ND; id++) begin
            cnt_se[id] = 0; cnt_en[id] = 0; cnt_clr[id] = 0; cnt_ev[id] = 0; cnt_sr[id] = 0;
            first_se[id] = -1; first_en[id] = -1; first_ev[id] = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int id = 0; id < ND; id++) begin
            int          np, per, idx;
            logic [63:0] e_se;
            logic        e_sr, e_clr, e_en, e_ev;
            bit          chk_sel;
            np = np_of(id);
            per = 2 + lat_of(id);
            idx = 0;
            e_se = '0; e_en = 1'b0; e_ev = 1'b0; chk_sel = 1'b0;
            e_sr = !m_busy[id];
            e_clr = !m_busy[id] && sample_valid;
            if (m_busy[id]) begin
                if (m_k[id] <= np * per) begin
                    if ((m_k[id] - 1) % per == 0) begin
                        idx = (m_k[id] - 1) / per;
                        e_se = 64'd1 << idx;
                        chk_sel = 1'b1;
                    end
                    if (m_k[id] % per == 0) begin
                        idx = m_k[id] / per - 1;
                        e_en = 1'b1;
                        chk_sel = 1'b1;
                    end
                end else begin
                    e_ev = 1'b1;
                end
            end
            chk($sformatf("sample_ready[%0d]", id), 64'(o_sr[id]), 64'(e_sr));
            chk($sformatf("accum_clr[%0d]", id), 64'(o_clr[id]), 64'(e_clr));
            chk($sformatf("start_encoding[%0d]", id), o_se[id], e_se);
            chk($sformatf("accum_en[%0d]", id), 64'(o_en[id]), 64'(e_en));
            chk($sformatf("enc_valid[%0d]", id), 64'(o_ev[id]), 64'(e_ev));
            if (chk_sel) chk($sformatf("pack_sel[%0d]", id), 64'(o_ps[id]), 64'(idx));
`ifdef ENC_SCHED_PERF_EN
            chk($sformatf("busy_cycles[%0d]", id), 64'(o_bc[id]), 64'(m_bc[id]));
`endif
            if (o_se[id] != 0) begin cnt_se[id]++; if (first_se[id] < 0) first_se[id] = rel; end
            if (o_en[id])      begin cnt_en[id]++; if (first_en[id] < 0) first_en[id] = rel; end
            if (o_ev[id])      begin cnt_ev[id]++; if (first_ev[id] < 0) first_ev[id] = rel; end
            if (o_clr[id]) cnt_clr[id]++;
            if (o_sr[id])  cnt_sr[id]++;
            if (!nrst) begin
                m_busy[id] = 1'b0;
                m_bc[id] = 0;
            end else begin
                if (m_busy[id] && m_bc[id] < 64'hFFFF_FFFF) m_bc[id]++;
                if (!m_busy[id]) begin
                    if (sample_valid) begin m_busy[id] = 1'b1; m_k[id] = 1; end
                end else if (m_k[id] > np * per) begin
                    if (enc_ready) m_busy[id] = 1'b0;
                end else begin
                    m_k[id]++;
                end
            end
        end
        rel++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; sample_valid = 1'b0; enc_ready = 1'b0;
        for (int id = 0; id < ND; id++) begin m_busy[id] = 1'b0; m_k[id] = 0; m_bc[id] = 0; end
        clear_stats();
        @(posedge clk);
        #1;
        chk("reset_sample_ready", 64'(sr0), 64'd1);
        chk("reset_enc_valid", 64'(ev0), 64'd0);
        chk("reset_start_encoding", 64'(se0), 64'd0);
        repeat (3) step();

        nrst = 1'b1; enc_ready = 1'b1; sample_valid = 1'b1;
        clear_stats();
        step();
        sample_valid = 1'b0;
        repeat (199) step();
        chk("t1_first_bind0", 64'(first_se[0]), 64'd1);
        chk("t1_first_accum0", 64'(first_en[0]), 64'd3);
        chk("t1_first_valid0", 64'(first_ev[0]), 64'd187);
        chk("t1_bind_pulses0", 64'(cnt_se[0]), 64'd62);
        chk("t1_accum_pulses0", 64'(cnt_en[0]), 64'd62);
        chk("t1_clr_pulses0", 64'(cnt_clr[0]), 64'd1);
        chk("t1_first_bind1", 64'(first_se[1]), 64'd1);
        chk("t1_first_accum1", 64'(first_en[1]), 64'd2);
        chk("t1_first_valid1", 64'(first_ev[1]), 64'd3);
        chk("t1_first_accum2", 64'(first_en[2]), 64'd5);
        chk("t1_first_valid2", 64'(first_ev[2]), 64'd21);
`ifdef ENC_SCHED_PERF_EN
        chk("t1_busy_cycles0", 64'(bc0), 64'd187);
`endif

        sample_valid = 1'b1;
        clear_stats();
        repeat (376) step();
        sample_valid = 1'b0;
        chk("t2_clr_pulses0", 64'(cnt_clr[0]), 64'd2);
        chk("t2_clr_pulses1", 64'(cnt_clr[1]), 64'd94);
        repeat (200) step();

        enc_ready = 1'b0; sample_valid = 1'b1;
        step();
        for (int i = 0; i < 300 && !ev0; i++) step();
        chk("t3_done_reached", 64'(ev0), 64'd1);
        clear_stats();
        repeat (20) step();
        chk("t3_valid_held", 64'(cnt_ev[0]), 64'd20);
        chk("t3_ready_low", 64'(cnt_sr[0]), 64'd0);
        chk("t3_no_bind", 64'(cnt_se[0]), 64'd0);
        enc_ready = 1'b1; sample_valid = 1'b0;
        repeat (200) step();

        sample_valid = 1'b1;
        clear_stats();
        step();
        sample_valid = 1'b0;
        repeat (49) step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("t4_rst_sample_ready", 64'(sr0), 64'd1);
        chk("t4_rst_start", 64'(se0), 64'd0);
        chk("t4_rst_accum_en", 64'(en0), 64'd0);
        chk("t4_rst_enc_valid", 64'(ev0), 64'd0);
        chk("t4_rst_pack_sel", 64'(ps0), 64'd0);
`ifdef ENC_SCHED_PERF_EN
        chk("t4_rst_busy", 64'(bc0), 64'd0);
`endif
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("t4_restart_bind", 64'(se0), 64'd1);
        chk("t4_restart_sel", 64'(ps0), 64'd0);
        repeat (200) step();

        repeat (3000) begin
            sample_valid = 1'($urandom_range(0, 1));
            enc_ready = ($urandom_range(0, 3) != 0);
            nrst = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
